// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings, geometry constants and helpers for the snake step controller
package snake_pkg;

  localparam logic [2:0] DIR_UP    = 3'b000;
  localparam logic [2:0] DIR_LEFT  = 3'b001;
  localparam logic [2:0] DIR_RIGHT = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;

  localparam logic [3:0]  LINK_SIZE = 4'd10;
  localparam logic [9:0]  START_X   = 10'd320;
  localparam logic [9:0]  START_Y   = 10'd240;
  localparam logic [9:0]  X_MIN     = 10'd0;
  localparam logic [9:0]  X_MAX     = 10'd629;
  localparam logic [9:0]  Y_MIN     = 10'd0;
  localparam logic [9:0]  Y_MAX     = 10'd469;
  localparam logic [12:0] START_LEN = 13'd3;
  localparam logic [12:0] MAX_LEN   = 13'd1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  function automatic logic [2:0] opposite(input logic [2:0] dir);
    case (dir)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = dir;
    endcase
  endfunction

endpackage

// File: rtl/dir_arbiter.sv
// rtl/dir_arbiter.sv - button priority encoder with reversal rejection, holds the pending direction
module dir_arbiter
  import snake_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_btn_up,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_down,
  input  logic [2:0] i_cur_dir,
  output logic [2:0] o_pend_dir
);

  logic [2:0] r_pend_dir;
  logic       w_req_valid;
  logic [2:0] w_req_dir;

  // Highest-priority button wins first; only then is it tested against a reversal.
  always_comb begin
    w_req_valid = 1'b1;
    w_req_dir   = DIR_RIGHT;
    if (i_btn_up) begin
      w_req_dir = DIR_UP;
    end else if (i_btn_left) begin
      w_req_dir = DIR_LEFT;
    end else if (i_btn_right) begin
      w_req_dir = DIR_RIGHT;
    end else if (i_btn_down) begin
      w_req_dir = DIR_DOWN;
    end else begin
      w_req_valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_dir <= DIR_RIGHT;
    end else if (i_en && w_req_valid && (w_req_dir != opposite(i_cur_dir))) begin
      r_pend_dir <= w_req_dir;
    end
  end

  assign o_pend_dir = r_pend_dir;

endmodule

// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - frame-rate sequencer: sub-link counter, head motion, link commit, growth, pause, game over
module snake_step_ctrl
  import snake_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_tick,
  input  logic        i_btn_up,
  input  logic        i_btn_left,
  input  logic        i_btn_right,
  input  logic        i_btn_down,
  input  logic        i_btn_pause,
  input  logic        i_start,
  input  logic        i_grow,
  input  logic        i_collision,
  output logic [3:0]  o_count,
  output logic [2:0]  o_next_direction,
  output logic [9:0]  o_head_x,
  output logic [9:0]  o_head_y,
  output logic [12:0] o_length,
  output logic        o_pause,
  output logic        o_step,
  output logic        o_game_over
);

  state_t      r_state;
  logic [3:0]  r_count;
  logic [2:0]  r_next_dir;
  logic [9:0]  r_head_x;
  logic [9:0]  r_head_y;
  logic [12:0] r_length;
  logic        r_grow_pend;
  logic        r_step;
  logic        r_pause;
  logic        r_game_over;
  logic        r_pause_btn_d;

  state_t      w_nxt_state;
  logic [3:0]  w_nxt_count;
  logic [2:0]  w_nxt_dir;
  logic [9:0]  w_nxt_x;
  logic [9:0]  w_nxt_y;
  logic [12:0] w_nxt_length;
  logic        w_nxt_grow_pend;
  logic        w_nxt_step;
  logic [9:0]  w_move_x;
  logic [9:0]  w_move_y;
  logic        w_wall;
  logic        w_pause_rise;
  logic        w_reload;
  logic        w_arb_en;
  logic [2:0]  w_pend_dir;

  assign w_pause_rise = i_btn_pause && !r_pause_btn_d;
  assign w_reload     = i_reset || ((r_state == ST_DEAD) && i_start);
  assign w_arb_en     = (r_state == ST_RUN) || (r_state == ST_PAUSED);

  dir_arbiter u_dir_arbiter (
    .i_clk       (i_clk),
    .i_reset     (w_reload),
    .i_en        (w_arb_en),
    .i_btn_up    (i_btn_up),
    .i_btn_left  (i_btn_left),
    .i_btn_right (i_btn_right),
    .i_btn_down  (i_btn_down),
    .i_cur_dir   (r_next_dir),
    .o_pend_dir  (w_pend_dir)
  );

  // Wall test looks at the current edge before stepping so 0-1 never wraps.
  always_comb begin
    w_move_x = r_head_x;
    w_move_y = r_head_y;
    w_wall   = 1'b0;
    case (r_next_dir)
      DIR_UP: begin
        w_wall   = (r_head_y == Y_MIN);
        w_move_y = r_head_y - 10'd1;
      end
      DIR_DOWN: begin
        w_wall   = (r_head_y == Y_MAX);
        w_move_y = r_head_y + 10'd1;
      end
      DIR_LEFT: begin
        w_wall   = (r_head_x == X_MIN);
        w_move_x = r_head_x - 10'd1;
      end
      DIR_RIGHT: begin
        w_wall   = (r_head_x == X_MAX);
        w_move_x = r_head_x + 10'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_count     = r_count;
    w_nxt_dir       = r_next_dir;
    w_nxt_x         = r_head_x;
    w_nxt_y         = r_head_y;
    w_nxt_length    = r_length;
    w_nxt_grow_pend = r_grow_pend;
    w_nxt_step      = 1'b0;

    if (i_grow && (r_state != ST_DEAD)) begin
      w_nxt_grow_pend = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (i_start) w_nxt_state = ST_RUN;
      end
      ST_RUN: begin
        if (i_collision) begin
          w_nxt_state = ST_DEAD;
        end else if (w_pause_rise) begin
          w_nxt_state = ST_PAUSED;
        end else if (i_frame_tick) begin
          if (r_count == LINK_SIZE) begin
            w_nxt_count = 4'd0;
            w_nxt_step  = 1'b1;
            w_nxt_dir   = w_pend_dir;
            if (r_grow_pend || i_grow) begin
              w_nxt_grow_pend = 1'b0;
              if (r_length != MAX_LEN) w_nxt_length = r_length + 13'd1;
            end
          end else if (w_wall) begin
            w_nxt_state = ST_DEAD;
          end else begin
            w_nxt_count = r_count + 4'd1;
            w_nxt_x     = w_move_x;
            w_nxt_y     = w_move_y;
          end
        end
      end
      ST_PAUSED: begin
        if (w_pause_rise) w_nxt_state = ST_RUN;
      end
      ST_DEAD: ;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Leaving DEAD via start reuses the reset load so every register restarts together.
  always_ff @(posedge i_clk) begin
    if (w_reload) begin
      r_state       <= ST_IDLE;
      r_count       <= 4'd0;
      r_next_dir    <= DIR_RIGHT;
      r_head_x      <= START_X;
      r_head_y      <= START_Y;
      r_length      <= START_LEN;
      r_grow_pend   <= 1'b0;
      r_step        <= 1'b0;
      r_pause       <= 1'b1;
      r_game_over   <= 1'b0;
      r_pause_btn_d <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_count       <= w_nxt_count;
      r_next_dir    <= w_nxt_dir;
      r_head_x      <= w_nxt_x;
      r_head_y      <= w_nxt_y;
      r_length      <= w_nxt_length;
      r_grow_pend   <= w_nxt_grow_pend;
      r_step        <= w_nxt_step;
      r_pause       <= (w_nxt_state != ST_RUN);
      r_game_over   <= (w_nxt_state == ST_DEAD);
      r_pause_btn_d <= i_btn_pause;
    end
  end

  assign o_count          = r_count;
  assign o_next_direction = r_next_dir;
  assign o_head_x         = r_head_x;
  assign o_head_y         = r_head_y;
  assign o_length         = r_length;
  assign o_pause          = r_pause;
  assign o_step           = r_step;
  assign o_game_over      = r_game_over;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb/tb_snake_step_ctrl.sv - scoreboard bench with a behavioural snake model, directed and random stimulus
module tb_snake_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, frame_tick, btn_up, btn_left, btn_right, btn_down, btn_pause, start, grow, collision;
  logic [3:0]  count;
  logic [2:0]  next_direction;
  logic [9:0]  head_x, head_y;
  logic [12:0] length;
  logic        pause, step, game_over;

  snake_step_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_frame_tick(frame_tick),
    .i_btn_up(btn_up), .i_btn_left(btn_left), .i_btn_right(btn_right), .i_btn_down(btn_down),
    .i_btn_pause(btn_pause), .i_start(start), .i_grow(grow), .i_collision(collision),
    .o_count(count), .o_next_direction(next_direction), .o_head_x(head_x), .o_head_y(head_y),
    .o_length(length), .o_pause(pause), .o_step(step), .o_game_over(game_over)
  );

  typedef struct packed {
    logic [3:0]  cnt;
    logic [2:0]  dir;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [12:0] len;
    logic        pau;
    logic        stp;
    logic        go;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_act, mon_exp;
  int    total = 0;
  int    bad = 0;
  string phase = "reset";

  // Behavioural model: directions 0 up, 1 left, 2 right, 3 down; opposite is 3-d.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DEAD = 3;
  int m_state, m_x, m_y, m_cnt, m_dir, m_pend, m_len;
  bit m_growp, m_bprev, m_step;

  task automatic model_reset();
    m_state = M_IDLE; m_x = 320; m_y = 240; m_cnt = 0; m_dir = 2; m_pend = 2;
    m_len = 3; m_growp = 0; m_bprev = 0; m_step = 0;
  endtask

  task automatic model_edge();
    int req, new_pend, s, nx, ny;
    bit rise;
    if (reset || (m_state == M_DEAD && start)) begin
      model_reset();
      return;
    end
    s = m_state;
    rise = btn_pause && !m_bprev;
    m_bprev = btn_pause;
    m_step = 0;
    req = btn_up ? 0 : btn_left ? 1 : btn_right ? 2 : btn_down ? 3 : -1;
    new_pend = m_pend;
    if ((s == M_RUN || s == M_PAUSED) && req >= 0 && req != 3 - m_dir) new_pend = req;
    if (grow && s != M_DEAD) m_growp = 1;
    if (s == M_IDLE && start) m_state = M_RUN;
    else if (s == M_PAUSED && rise) m_state = M_RUN;
    else if (s == M_RUN) begin
      if (collision) m_state = M_DEAD;
      else if (rise) m_state = M_PAUSED;
      else if (frame_tick) begin
        if (m_cnt == 10) begin
          m_cnt = 0; m_step = 1; m_dir = m_pend;
          if (m_growp) begin
            m_growp = 0;
            m_len = (m_len + 1 > 1000) ? 1000 : m_len + 1;
          end
        end else begin
          nx = m_x + ((m_dir == 2) ? 1 : 0) - ((m_dir == 1) ? 1 : 0);
          ny = m_y + ((m_dir == 3) ? 1 : 0) - ((m_dir == 0) ? 1 : 0);
          if (nx < 0 || nx > 629 || ny < 0 || ny > 469) m_state = M_DEAD;
          else begin
            m_x = nx; m_y = ny; m_cnt = m_cnt + 1;
          end
        end
      end
    end
    m_pend = new_pend;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.cnt = 4'(m_cnt); s.dir = 3'(m_dir); s.x = 10'(m_x); s.y = 10'(m_y); s.len = 13'(m_len);
    s.pau = (m_state != M_RUN); s.stp = m_step; s.go = (m_state == M_DEAD);
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {count, next_direction, head_x, head_y, length, pause, step, game_over};
      total++;
      if (mon_act !== mon_exp) begin
        bad++;
        $display("FAIL %s t=%0t: got cnt=%0d dir=%0d x=%0d y=%0d len=%0d pause=%0b step=%0b go=%0b required cnt=%0d dir=%0d x=%0d y=%0d len=%0d pause=%0b step=%0b go=%0b",
                 phase, $time, mon_act.cnt, mon_act.dir, mon_act.x, mon_act.y, mon_act.len, mon_act.pau, mon_act.stp, mon_act.go,
                 mon_exp.cnt, mon_exp.dir, mon_exp.x, mon_exp.y, mon_exp.len, mon_exp.pau, mon_exp.stp, mon_exp.go);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_snap());
    #1;
    frame_tick = 0; start = 0; grow = 0; collision = 0; reset = 0;
  endtask

  task automatic tick();
    frame_tick = 1;
    cyc();
  endtask

  task automatic set_btn(input int d);
    btn_up = (d == 0); btn_left = (d == 1); btn_right = (d == 2); btn_down = (d == 3);
  endtask

  int nsteps, saved_cnt, saved_y;
  int seq[4] = '{2, 3, 1, 0};

  initial begin
    reset = 1; frame_tick = 0; btn_up = 0; btn_left = 0; btn_right = 0; btn_down = 0;
    btn_pause = 0; start = 0; grow = 0; collision = 0;
    model_reset();
    reset = 1; cyc();
    reset = 1; cyc();
    chk("reset_head_x", head_x, 320);
    chk("reset_pause", pause, 1);

    phase = "first_link";
    start = 1; cyc();
    nsteps = 0;
    for (int i = 0; i < 11; i++) begin
      tick(); nsteps += step;
      if (i == 9) chk("count_at_10", count, 10);
      cyc(); nsteps += step;
    end
    chk("link_head_x", head_x, 330);
    chk("link_count", count, 0);
    chk("link_steps", nsteps, 1);
    chk("link_dir", next_direction, 2);

    phase = "steer";
    for (int i = 0; i < 3; i++) tick();
    btn_left = 1; cyc(); btn_left = 0;
    tick();
    btn_up = 1; cyc(); btn_up = 0;
    for (int i = 0; i < 20 && m_cnt != 10; i++) tick();
    chk("dir_before_step", next_direction, 2);
    tick();
    chk("dir_after_step", next_direction, 0);
    saved_y = head_y;
    for (int i = 0; i < 3; i++) tick();
    chk("up_moves_y", head_y, saved_y - 3);

    phase = "grow";
    grow = 1; cyc();
    tick();
    grow = 1; cyc();
    for (int i = 0; i < 20 && m_cnt != 10; i++) tick();
    tick();
    chk("grow_twice_len", length, 4);
    for (int i = 0; i < 20 && m_cnt != 10; i++) tick();
    grow = 1; tick();
    chk("grow_on_boundary_len", length, 5);

    phase = "pause";
    for (int i = 0; i < 4; i++) tick();
    btn_pause = 1; tick();
    saved_cnt = count; saved_y = head_y;
    for (int i = 0; i < 20; i++) tick();
    chk("paused_count", count, saved_cnt);
    chk("paused_head_y", head_y, saved_y);
    chk("paused_flag", pause, 1);
    btn_pause = 0; cyc();
    btn_pause = 1; cyc();
    btn_pause = 0; tick();
    chk("resume_count", count, saved_cnt + 1);

    phase = "wall";
    btn_right = 1; cyc(); btn_right = 0;
    for (int i = 0; i < 2000 && m_state != M_DEAD; i++) tick();
    chk("wall_game_over", game_over, 1);
    chk("wall_head_x", head_x, 629);
    tick(); tick();
    chk("wall_hold_x", head_x, 629);
    start = 1; cyc();
    chk("restart_x", head_x, 320);
    chk("restart_y", head_y, 240);
    chk("restart_go", game_over, 0);

    phase = "collision";
    start = 1; cyc();
    for (int i = 0; i < 20 && m_cnt != 10; i++) tick();
    collision = 1; tick();
    chk("coll_step", step, 0);
    chk("coll_go", game_over, 1);
    chk("coll_count", count, 10);
    start = 1; cyc();
    start = 1; cyc();
    for (int i = 0; i < 5; i++) tick();
    reset = 1; cyc();
    chk("midrun_reset_x", head_x, 320);
    chk("midrun_reset_count", count, 0);
    chk("midrun_reset_pause", pause, 1);

    phase = "max_len";
    start = 1; cyc();
    for (int k = 0; k < 1010; k++) begin
      set_btn(seq[((k + 1) / 20) % 4]);
      grow = 1; tick();
      set_btn(-1);
      for (int j = 0; j < 10; j++) tick();
    end
    chk("max_len", length, 1000);
    chk("max_len_alive", game_over, 0);

    phase = "random";
    reset = 1; cyc();
    start = 1; cyc();
    for (int i = 0; i < 4000; i++) begin
      frame_tick = $urandom_range(0, 1);
      btn_up = ($urandom_range(0, 7) == 0);
      btn_left = ($urandom_range(0, 7) == 0);
      btn_right = ($urandom_range(0, 7) == 0);
      btn_down = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) btn_pause = ~btn_pause;
      start = ($urandom_range(0, 99) == 0);
      grow = ($urandom_range(0, 15) == 0);
      collision = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc();
    end
    set_btn(-1); btn_pause = 0;
    cyc();
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
